// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types and helpers for the ALU self-test logic.
//   - alu_op_e      : ALU opcode encoding (AND/XOR/ADD/SUB)
//   - bist_state_e  : self-test controller states
//   - alu_golden    : reference ALU result, masked to the requested width
//   - lfsr32_next   : one step of the 32-bit Fibonacci LFSR (taps 32,22,2,1)
//   - lfsr32_seed   : seed sanitiser (an all-zero seed would lock the LFSR)
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_AND = 2'd0,
        ALU_XOR = 2'd1,
        ALU_ADD = 2'd2,
        ALU_SUB = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    // Operands and result are carried in a 16-bit container (the widest legal
    // ALU); bits at and above 'width' are forced to zero.
    function automatic logic [15:0] alu_golden(input alu_op_e     op,
                                               input logic [15:0] a,
                                               input logic [15:0] b,
                                               input int unsigned width);
        logic [15:0] r;
        logic [16:0] mask_w;
        r = '0;
        case (op)
            ALU_AND: r = a & b;
            ALU_XOR: r = a ^ b;
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            default: r = '0;
        endcase
        mask_w = (17'd1 << width) - 17'd1;
        return r & mask_w[15:0];
    endfunction

    // Shift left, feedback into bit 0 from taps 32,22,2,1.
    function automatic logic [31:0] lfsr32_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] lfsr32_seed(input logic [31:0] seed);
        return (seed == 32'd0) ? 32'd1 : seed;
    endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// ---------------------------------------------------------------------------
// bist_lfsr32
//   32-bit Fibonacci LFSR used as the operand source of the ALU self-test.
//   Ports:
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     load        : reload the (sanitised) seed; wins over step
//     step        : advance one LFSR step
//     state       : current 32-bit LFSR state
//     next_ops    : low OPS_W bits of the state after one more step, so the
//                   owner can register the next operands on the same edge
//                   that advances the LFSR
// ---------------------------------------------------------------------------
module bist_lfsr32
    import alu_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'hACE1,
    parameter int          OPS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [31:0]      state,
    output logic [OPS_W-1:0] next_ops
);

    localparam logic [31:0] SEED_EFF = lfsr32_seed(SEED);

    logic [31:0] next_state;

    assign next_state = lfsr32_next(state);
    assign next_ops   = next_state[OPS_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_EFF;
        end else if (load) begin
            state <= SEED_EFF;
        end else if (step) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/alu_bist_driver.sv
// ---------------------------------------------------------------------------
// alu_bist_driver
//   Self-test initiator for an external combinational ALU. Each run walks
//   NUM_VECTORS LFSR operand pairs through all four opcodes, holding every
//   operand set for SETTLE_CYCLES cycles before sampling alu_result and
//   comparing it with the golden model.
//
//   Handshake: start is a one-cycle request, honoured only in IDLE or DONE;
//   abort is synchronous, always honoured and wins over a same-cycle start.
//   There is no back-pressure; done is a level held until start/abort/reset.
//
//   Ports:
//     clk, rst_n   : clock (rising edge), asynchronous active-low reset
//     start, abort : run request / synchronous stop
//     alu_a, alu_b : operands to the ALU (upper/lower WIDTH bits of the LFSR)
//     alu_op       : opcode to the ALU
//     alu_result   : ALU result, sampled in CHECK
//     busy         : high from the first DRIVE through the last CHECK
//     done, pass   : run finished / finished with no mismatch
//     err_count    : saturating mismatch count
//     fail_vec     : vector index of the first mismatch
//     fail_op      : opcode of the first mismatch
//     dbg_state    : controller state
//     dbg_lfsr     : current LFSR state
// ---------------------------------------------------------------------------
module alu_bist_driver
    import alu_pkg::*;
#(
    parameter int          WIDTH         = 8,
    parameter int          NUM_VECTORS   = 16,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] SEED          = 32'hACE1,
    parameter int          ERR_W         = 8,
    localparam int         VEC_W         = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] fail_vec,
    output logic [1:0]       fail_op,
    output bist_state_e      dbg_state,
    output logic [31:0]      dbg_lfsr
);

    localparam int               SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [31:0]      SEED_EFF    = lfsr32_seed(SEED);

    bist_state_e          state;
    alu_op_e              op_q;
    logic [VEC_W-1:0]     vec;
    logic [SET_W-1:0]     settle_cnt;
    logic [31:0]          lfsr_state;
    logic [2*WIDTH-1:0]   lfsr_next_ops;
    logic                 accept;
    logic                 lfsr_step;
    logic                 mismatch;
    logic [15:0]          golden;
    logic [ERR_W-1:0]     err_inc;

    // A run (re)starts only from IDLE or DONE, and never when abort is high.
    assign accept    = start && !abort && (state == IDLE || state == DONE);
    // Step only when moving on to the next vector, so the LFSR state always
    // matches the operands on the pins.
    assign lfsr_step = !abort && (state == CHECK) && (op_q == ALU_SUB) && (vec != VEC_LAST);

    bist_lfsr32 #(
        .SEED  (SEED),
        .OPS_W (2 * WIDTH)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (lfsr_step),
        .state    (lfsr_state),
        .next_ops (lfsr_next_ops)
    );

    // Compare in the 16-bit container: golden is already masked and the
    // zero-extended result must match it in every bit.
    assign golden   = alu_golden(op_q, 16'(alu_a), 16'(alu_b), WIDTH);
    assign mismatch = (16'(alu_result) != golden);
    assign err_inc  = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);

    assign alu_op    = op_q;
    assign dbg_state = state;
    assign dbg_lfsr  = lfsr_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= ALU_AND;
            vec        <= '0;
            settle_cnt <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_op    <= 2'd0;
        end else if (abort) begin
            // Results of the interrupted run stay visible for inspection.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_op    <= 2'd0;
                        vec        <= '0;
                        op_q       <= ALU_AND;
                        settle_cnt <= '0;
                        alu_a      <= SEED_EFF[2*WIDTH-1:WIDTH];
                        alu_b      <= SEED_EFF[WIDTH-1:0];
                    end
                end

                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end

                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_inc;
                        // err_count never returns to zero within a run, so
                        // zero marks the first mismatch.
                        if (err_count == '0) begin
                            fail_vec <= vec;
                            fail_op  <= op_q;
                        end
                    end
                    settle_cnt <= '0;
                    if (op_q != ALU_SUB) begin
                        op_q  <= alu_op_e'(op_q + 2'd1);
                        state <= DRIVE;
                    end else if (vec != VEC_LAST) begin
                        op_q  <= ALU_AND;
                        vec   <= vec + VEC_W'(1);
                        alu_a <= lfsr_next_ops[2*WIDTH-1:WIDTH];
                        alu_b <= lfsr_next_ops[WIDTH-1:0];
                        state <= DRIVE;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
